// File: rtl/fft_test_core.sv
// fft_test_core: 64-point radix-2 DIT FFT for one 12-bit ADC channel.
// Captures a frame in bit-reversed order, transforms it in place with one butterfly, streams the bins.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_CAPTURE | store samples 0..63 at bitrev6(k), imaginary part cleared
// ST_COMPUTE | 6 stages x 32 butterflies, one butterfly per clock
// ST_OUTPUT  | register bins 0..63 in natural order with their |X|^2
module fft_test_core #(
  localparam int N  = 64,
  localparam int IW = 12,
  localparam int OW = 19,
  localparam int AW = 43
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  input  logic [IW-1:0]        input_data_ch1,
  output logic signed [OW-1:0] fft_real,
  output logic signed [OW-1:0] fft_imag,
  output logic [AW-1:0]        amp,
  output logic                 fft_out_valid
);

  typedef enum logic [1:0] {ST_CAPTURE, ST_COMPUTE, ST_OUTPUT} state_t;

  state_t     state, state_next;
  logic [7:0] cnt, cnt_next;

  logic signed [OW-1:0] mem_re [N];
  logic signed [OW-1:0] mem_im [N];

  // Quarter-wave cosine in Q2.16; the 32-entry twiddle table is folded onto it.
  function automatic logic signed [17:0] cos_q(input logic [4:0] k);
    case (k)
      5'd0:    cos_q = 18'sd65536;
      5'd1:    cos_q = 18'sd65220;
      5'd2:    cos_q = 18'sd64277;
      5'd3:    cos_q = 18'sd62714;
      5'd4:    cos_q = 18'sd60547;
      5'd5:    cos_q = 18'sd57798;
      5'd6:    cos_q = 18'sd54491;
      5'd7:    cos_q = 18'sd50660;
      5'd8:    cos_q = 18'sd46341;
      5'd9:    cos_q = 18'sd41576;
      5'd10:   cos_q = 18'sd36410;
      5'd11:   cos_q = 18'sd30893;
      5'd12:   cos_q = 18'sd25080;
      5'd13:   cos_q = 18'sd19024;
      5'd14:   cos_q = 18'sd12785;
      5'd15:   cos_q = 18'sd6424;
      default: cos_q = 18'sd0;
    endcase
  endfunction

  // ---------------- sequencing ----------------
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state <= ST_CAPTURE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt + 8'd1;
    case (state)
      ST_CAPTURE: if (cnt == 8'd63) begin
        state_next = ST_COMPUTE;
        cnt_next   = '0;
      end
      ST_COMPUTE: if (cnt == 8'd191) begin
        state_next = ST_OUTPUT;
        cnt_next   = '0;
      end
      ST_OUTPUT: if (cnt == 8'd63) begin
        state_next = ST_CAPTURE;
        cnt_next   = '0;
      end
      default: begin
        state_next = ST_CAPTURE;
        cnt_next   = '0;
      end
    endcase
  end

  // ---------------- butterfly addressing ----------------
  logic [2:0] stage;
  logic [4:0] bfly;
  logic [5:0] span, pos, top, bot;
  logic [4:0] tw_idx, k_re, k_im;
  logic signed [17:0] wr, wi;

  always_comb begin
    stage  = cnt[7:5];
    bfly   = cnt[4:0];
    span   = 6'd1 << stage;
    pos    = {1'b0, bfly} & (span - 6'd1);
    top    = (({1'b0, bfly} >> stage) << (stage + 3'd1)) | pos;
    bot    = top | span;
    tw_idx = 5'(pos << (3'd5 - stage));
    k_re   = tw_idx[4] ? 5'(6'd32 - {1'b0, tw_idx}) : tw_idx;
    k_im   = tw_idx[4] ? {1'b0, tw_idx[3:0]} : (5'd16 - tw_idx);
    wr     = tw_idx[4] ? -cos_q(k_re) : cos_q(k_re);
    wi     = -cos_q(k_im);
  end

  // ---------------- butterfly datapath ----------------
  logic signed [OW-1:0] a_re, a_im, b_re, b_im;
  logic signed [38:0]   p_re_full, p_im_full;
  logic signed [OW-1:0] p_re, p_im;
  logic signed [OW-1:0] top_re, top_im, bot_re, bot_im;

  always_comb begin
    a_re      = mem_re[top];
    a_im      = mem_im[top];
    b_re      = mem_re[bot];
    b_im      = mem_im[bot];
    p_re_full = 39'(b_re) * 39'(wr) - 39'(b_im) * 39'(wi) + 39'sd32768;
    p_im_full = 39'(b_re) * 39'(wi) + 39'(b_im) * 39'(wr) + 39'sd32768;
    // Sums wrap in 19 bits; the bin range is sized so legal inputs never overflow.
    p_re      = 19'(p_re_full >>> 16);
    p_im      = 19'(p_im_full >>> 16);
    top_re    = a_re + p_re;
    top_im    = a_im + p_im;
    bot_re    = a_re - p_re;
    bot_im    = a_im - p_im;
  end

  logic [5:0]          cap_addr;
  logic signed [IW-1:0] sample_s;

  assign cap_addr = {cnt[0], cnt[1], cnt[2], cnt[3], cnt[4], cnt[5]};
  assign sample_s = {~input_data_ch1[IW-1], input_data_ch1[IW-2:0]};

  // Working store is never cleared; each frame fully overwrites it during capture.
  always_ff @(posedge aclk) begin
    if (state == ST_CAPTURE) begin
      mem_re[cap_addr] <= 19'(sample_s);
      mem_im[cap_addr] <= '0;
    end else if (state == ST_COMPUTE) begin
      mem_re[top] <= top_re;
      mem_im[top] <= top_im;
      mem_re[bot] <= bot_re;
      mem_im[bot] <= bot_im;
    end
  end

  // ---------------- output stage ----------------
  logic signed [OW-1:0] rd_re, rd_im;
  logic signed [37:0]   sq_re, sq_im;
  logic [AW-1:0]        amp_next;

  always_comb begin
    rd_re    = mem_re[cnt[5:0]];
    rd_im    = mem_im[cnt[5:0]];
    sq_re    = 38'(rd_re) * 38'(rd_re);
    sq_im    = 38'(rd_im) * 38'(rd_im);
    amp_next = {5'd0, sq_re} + {5'd0, sq_im};
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      fft_real      <= '0;
      fft_imag      <= '0;
      amp           <= '0;
      fft_out_valid <= 1'b0;
    end else if (state == ST_OUTPUT) begin
      fft_real      <= rd_re;
      fft_imag      <= rd_im;
      amp           <= amp_next;
      fft_out_valid <= 1'b1;
    end else begin
      fft_real      <= '0;
      fft_imag      <= '0;
      amp           <= '0;
      fft_out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fft_test_core.sv
// Directed bench for fft_test_core: constant, impulse and alternating frames,
// burst timing, reset mid-frame and input changes outside capture.
module tb_fft_test_core;

  logic               aclk = 1'b0;
  logic               aresetn = 1'b1;
  logic [11:0]        input_data_ch1 = 12'h800;
  logic signed [18:0] fft_real;
  logic signed [18:0] fft_imag;
  logic [42:0]        amp;
  logic               fft_out_valid;

  int errors = 0;
  int checks = 0;

  logic [11:0]        frame [64];
  logic [11:0]        junk = 12'h000;
  logic signed [63:0] got_re [64];
  logic signed [63:0] got_im [64];
  logic signed [63:0] got_amp [64];
  int e, first_valid, vcount, zero_viol;

  fft_test_core dut (
    .aclk           (aclk),
    .aresetn        (aresetn),
    .input_data_ch1 (input_data_ch1),
    .fft_real       (fft_real),
    .fft_imag       (fft_imag),
    .amp            (amp),
    .fft_out_valid  (fft_out_valid)
  );

  always #5 aclk = ~aclk;

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic chk_tol(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp_v);
    checks++;
    assert (obs >= exp_v - 2 && obs <= exp_v + 2) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d +/-2", tag, obs, exp_v);
    end
  endtask

  task automatic set_const(input logic [11:0] v);
    for (int k = 0; k < 64; k++) frame[k] = v;
  endtask

  task automatic start_frame();
    e = 0;
    first_valid = -1;
    vcount = 0;
    zero_viol = 0;
  endtask

  // One clock edge: drive sample e (or junk outside capture), then sample outputs #1 later.
  task automatic step();
    input_data_ch1 = (e < 64) ? frame[e] : junk;
    @(posedge aclk);
    #1;
    if (fft_out_valid === 1'b1) begin
      vcount++;
      if (first_valid < 0) first_valid = e;
    end else if (fft_real !== '0 || fft_imag !== '0 || amp !== '0) begin
      zero_viol++;
    end
    if (e >= 256 && e < 320) begin
      got_re[e-256]  = fft_real;
      got_im[e-256]  = fft_imag;
      got_amp[e-256] = amp;
    end
    e++;
  endtask

  task automatic run_frame();
    start_frame();
    repeat (320) step();
  endtask

  task automatic check_timing(input string tag);
    chk({tag, " first_valid_edge"}, first_valid, 256);
    chk({tag, " valid_cycles"}, vcount, 64);
    chk({tag, " zero_when_idle"}, zero_viol, 0);
  endtask

  task automatic check_const_fff(input string tag);
    chk({tag, " bin0 re"}, got_re[0], 131008);
    chk({tag, " bin0 im"}, got_im[0], 0);
    chk({tag, " bin0 amp"}, got_amp[0], 64'sd17163096064);
    for (int i = 1; i < 64; i++) begin
      chk($sformatf("%s bin%0d re", tag, i), got_re[i], 0);
      chk($sformatf("%s bin%0d im", tag, i), got_im[i], 0);
      chk($sformatf("%s bin%0d amp", tag, i), got_amp[i], 0);
    end
  endtask

  initial begin
    // reset state
    #2 aresetn = 1'b0;
    repeat (3) @(posedge aclk);
    #1;
    chk("rst valid", fft_out_valid, 0);
    chk("rst real", fft_real, 0);
    chk("rst imag", fft_imag, 0);
    chk("rst amp", amp, 0);
    @(negedge aclk);
    aresetn = 1'b1;

    // full-scale DC; inputs forced to 0x000 outside capture
    set_const(12'hFFF);
    run_frame();
    check_timing("dc_fff");
    check_const_fff("dc_fff");
    run_frame();
    check_timing("dc_fff_repeat");
    chk("dc_fff_repeat bin0 re", got_re[0], 131008);
    chk("dc_fff_repeat bin1 re", got_re[1], 0);

    // mid-scale DC: silence
    set_const(12'h800);
    run_frame();
    check_timing("dc_800");
    for (int i = 0; i < 64; i++) begin
      chk($sformatf("dc_800 bin%0d re", i), got_re[i], 0);
      chk($sformatf("dc_800 bin%0d im", i), got_im[i], 0);
      chk($sformatf("dc_800 bin%0d amp", i), got_amp[i], 0);
    end

    // impulse: flat spectrum
    set_const(12'h800);
    frame[0] = 12'hFFF;
    run_frame();
    check_timing("impulse");
    chk("impulse bin0 amp", got_amp[0], 4190209);
    for (int i = 0; i < 64; i++) begin
      chk_tol($sformatf("impulse bin%0d re", i), got_re[i], 2047);
      chk_tol($sformatf("impulse bin%0d im", i), got_im[i], 0);
    end

    // +2047/-2047 alternating: all energy in bin 32
    for (int k = 0; k < 64; k++) frame[k] = (k % 2 == 0) ? 12'hFFF : 12'h001;
    run_frame();
    check_timing("alt");
    for (int i = 0; i < 64; i++) begin
      chk_tol($sformatf("alt bin%0d re", i), got_re[i], (i == 32) ? 131008 : 0);
      chk_tol($sformatf("alt bin%0d im", i), got_im[i], 0);
    end

    // reset at edge 150 (COMPUTE), then a fresh frame
    set_const(12'h800);
    frame[0] = 12'hFFF;
    start_frame();
    repeat (151) step();
    aresetn = 1'b0;
    #1;
    chk("rst_compute valid", fft_out_valid, 0);
    chk("rst_compute real", fft_real, 0);
    chk("rst_compute amp", amp, 0);
    @(negedge aclk);
    @(negedge aclk);
    aresetn = 1'b1;
    set_const(12'hFFF);
    run_frame();
    check_timing("after_rst_compute");
    chk("after_rst_compute bin0 re", got_re[0], 131008);
    chk("after_rst_compute bin0 amp", got_amp[0], 64'sd17163096064);
    chk("after_rst_compute bin5 re", got_re[5], 0);

    // reset while bins are streaming clears outputs at once
    set_const(12'h800);
    frame[0] = 12'hFFF;
    start_frame();
    repeat (271) step();
    chk("pre_rst_output valid", fft_out_valid, 1);
    chk_tol("pre_rst_output real", fft_real, 2047);
    aresetn = 1'b0;
    #1;
    chk("rst_output valid", fft_out_valid, 0);
    chk("rst_output real", fft_real, 0);
    chk("rst_output imag", fft_imag, 0);
    chk("rst_output amp", amp, 0);
    @(negedge aclk);
    aresetn = 1'b1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
